// File: rtl/decoder_pkg.sv
// Shared types and helpers for the 3-to-8 stream decoder.
package decoder_pkg;

  localparam int CODE_W   = 3;
  localparam int ONEHOT_W = 8;

  typedef logic [CODE_W-1:0]   code_t;
  typedef logic [ONEHOT_W-1:0] onehot_t;

  // Buffer occupancy doubles as the control state.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  // Binary code to one-hot word: bit k set iff code == k.
  function automatic onehot_t code_to_onehot(input code_t code);
    return onehot_t'(1) << code;
  endfunction

endpackage

// File: rtl/decoder_fifo2.sv
// Two-entry code buffer: 1-bit read/write pointers, occupancy state,
// ready/valid derived from registered occupancy only.
module decoder_fifo2
  import decoder_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  push_i,
  input  code_t data_i,
  output logic  ready_o,
  input  logic  pop_i,
  output logic  valid_o,
  output code_t head_o
);

  occ_e  occ_q;
  logic  wptr_q;
  logic  rptr_q;
  code_t mem_q [2];

  logic accept;
  logic emit;

  // Handshake qualifiers come from registered state, so ready never depends on pop_i.
  always_comb begin
    ready_o = (occ_q != FULL);
    valid_o = (occ_q != EMPTY);
    accept  = push_i && ready_o;
    emit    = pop_i && valid_o;
    head_o  = mem_q[rptr_q];
  end

  // Occupancy state and pointers; reset wins over any concurrent transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q  <= EMPTY;
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
    end else begin
      if (accept) wptr_q <= ~wptr_q;
      if (emit)   rptr_q <= ~rptr_q;
      if (accept && !emit) begin
        occ_q <= (occ_q == EMPTY) ? ONE : FULL;
      end else if (emit && !accept) begin
        occ_q <= (occ_q == FULL) ? ONE : EMPTY;
      end
    end
  end

  // Storage is data only; stale entries are never visible because valid gates them.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/decoder_3x8_stream.sv
// Registered 3-to-8 one-hot decoder with valid/ready stream and 2-entry buffer.
// Optional transfer counter enabled by defining DECODE_COUNT_EN.
module decoder_3x8_stream
  import decoder_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_code,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_onehot
`ifdef DECODE_COUNT_EN
  ,
  output logic [CNT_W-1:0] out_count
`endif
);

  code_t head;

  decoder_fifo2 u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_valid),
    .data_i  (in_code),
    .ready_o (in_ready),
    .pop_i   (out_ready),
    .valid_o (out_valid),
    .head_o  (head)
  );

  // Decode the head entry; force zero when nothing is buffered so the output is never X.
  always_comb begin
    out_onehot = out_valid ? code_to_onehot(head) : '0;
  end

`ifdef DECODE_COUNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: one per completed output transfer, wrapping naturally.
  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && out_ready) cnt_d = cnt_q + CNT_W'(1);
  end

  // Transfer counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign out_count = cnt_q;
`endif

endmodule

// File: tb/tb_decoder_3x8_stream.sv
// Directed self-checking bench for decoder_3x8_stream.
module tb_decoder_3x8_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_code;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_onehot;
`ifdef DECODE_COUNT_EN
  logic [3:0] out_count;
`endif

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  decoder_3x8_stream #(.CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_code    (in_code),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_onehot (out_onehot)
`ifdef DECODE_COUNT_EN
    ,
    .out_count  (out_count)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset held two cycles while a code is offered.
    rst = 1'b1; in_valid = 1'b1; in_code = 3'd5; out_ready = 1'b0;
    step();
    chk("rst1_in_ready", in_ready, 1);
    chk("rst1_out_valid", out_valid, 0);
    chk("rst1_onehot", out_onehot, 8'h00);
    step();
    chk("rst2_in_ready", in_ready, 1);
    chk("rst2_out_valid", out_valid, 0);
    chk("rst2_onehot", out_onehot, 8'h00);
    rst = 1'b0; in_valid = 1'b0;
    step();
    chk("post_rst_empty", out_valid, 0);
    chk("post_rst_onehot", out_onehot, 8'h00);

    // Exhaustive decode at full rate.
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; in_code = 3'(k);
      step();
      chk("exh_valid", out_valid, 1);
      chk("exh_onehot", out_onehot, 32'(8'h01 << k));
      chk("exh_in_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    step();
    chk("exh_drain", out_valid, 0);

    // Backpressure: two codes absorbed, third held off.
    out_ready = 1'b0;
    in_valid = 1'b1; in_code = 3'd3;
    step();
    chk("bp_one_ready", in_ready, 1);
    chk("bp_one_onehot", out_onehot, 8'h08);
    in_code = 3'd6;
    step();
    chk("bp_full_ready", in_ready, 0);
    chk("bp_full_onehot", out_onehot, 8'h08);
    in_code = 3'd1;
    step();
    chk("bp_hold_ready", in_ready, 0);
    chk("bp_hold_valid", out_valid, 1);
    chk("bp_hold_onehot", out_onehot, 8'h08);
    out_ready = 1'b1;
    step();
    chk("bp_rec_ready", in_ready, 1);
    chk("bp_rec_onehot", out_onehot, 8'h40);
    step();
    chk("bp_last_onehot", out_onehot, 8'h02);
    chk("bp_last_valid", out_valid, 1);
    in_valid = 1'b0;
    step();
    chk("bp_drain", out_valid, 0);

    // Simultaneous accept and emit while holding one entry.
    out_ready = 1'b0;
    in_valid = 1'b1; in_code = 3'd2;
    step();
    chk("sim_head", out_onehot, 8'h04);
    out_ready = 1'b1; in_code = 3'd7;
    step();
    chk("sim_new_head", out_onehot, 8'h80);
    chk("sim_valid", out_valid, 1);
    chk("sim_ready", in_ready, 1);
    in_valid = 1'b0;
    step();
    chk("sim_drain", out_valid, 0);

    // Mid-stream reset discards buffered codes.
    out_ready = 1'b0;
    in_valid = 1'b1; in_code = 3'd4;
    step();
    in_code = 3'd5;
    step();
    chk("mr_full", in_ready, 0);
    in_valid = 1'b0; rst = 1'b1;
    step();
    chk("mr_valid", out_valid, 0);
    chk("mr_ready", in_ready, 1);
    chk("mr_onehot", out_onehot, 8'h00);
    rst = 1'b0; in_valid = 1'b1; in_code = 3'd0;
    step();
    chk("mr_new_onehot", out_onehot, 8'h01);
    chk("mr_new_valid", out_valid, 1);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("mr_no_stale", out_valid, 0);

`ifdef DECODE_COUNT_EN
    // Counter wraps after 16 emits; 17 leaves it at 1.
    rst = 1'b1;
    step();
    chk("cnt_reset", out_count, 0);
    rst = 1'b0;
    for (int k = 0; k < 17; k++) begin
      in_valid = 1'b1; in_code = 3'(k);
      step();
    end
    in_valid = 1'b0;
    step();
    chk("cnt_wrap", out_count, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
